// File: rtl/nn_eval_pkg.sv
// nn_eval_pkg -- shared definitions for the single-neuron evaluation scorer.
//   state_t      : scorer FSM states
//   *_DEF        : default geometry / widths for nn_eval_scorer
//   PIX_QSHIFT   : pixel is placed in the integer part of a Q8.8 operand
//   LABEL_POS/NEG: label encodings
package nn_eval_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ACCEPT,
        DECIDE,
        FINISH
    } state_t;

    localparam int N_PIX_DEF     = 784;
    localparam int N_SAMPLES_DEF = 40;
    localparam int W_W_DEF       = 16;
    localparam int PIX_W_DEF     = 8;
    localparam int ACC_W_DEF     = 48;

    localparam int PIX_QSHIFT = 8;

    localparam logic LABEL_POS = 1'b1;
    localparam logic LABEL_NEG = 1'b0;

endpackage

// File: rtl/nn_eval_mac.sv
// nn_eval_mac -- signed multiply-accumulate for one pixel/weight pair.
//   clk, rst  : clock, synchronous active-high reset (clears acc)
//   en        : accumulate this cycle
//   clr_first : restart the sum with this product (first pixel of an image)
//   pix       : unsigned pixel, widened to {0, pix, 8'b0} (Q8.8)
//   w         : signed weight
//   acc       : signed running sum, wraps modulo 2^ACC_W
module nn_eval_mac
    import nn_eval_pkg::*;
#(
    parameter int W_W   = W_W_DEF,
    parameter int PIX_W = PIX_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    clr_first,
    input  logic [PIX_W-1:0]        pix,
    input  logic signed [W_W-1:0]   w,
    output logic signed [ACC_W-1:0] acc
);

    localparam int X_W = PIX_W + PIX_QSHIFT + 1;
    localparam int P_W = X_W + W_W;

    logic signed [X_W-1:0]   x;
    logic signed [P_W-1:0]   prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_reg;

    // Leading zero keeps the pixel operand non-negative in the signed multiply.
    assign x        = {1'b0, pix, {PIX_QSHIFT{1'b0}}};
    assign prod     = x * w;
    assign prod_ext = {{(ACC_W-P_W){prod[P_W-1]}}, prod};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= (clr_first ? '0 : acc_reg) + prod_ext;
        end
    end

    assign acc = acc_reg;

endmodule

// File: rtl/nn_eval_scorer.sv
// nn_eval_scorer -- scores a trained weight vector against held-out images.
// Per image: fetch weight, accept pixel, accumulate z; then predict z >= 0,
// compare with the label captured on pixel 0 and count correct predictions.
//   start/busy/done          : run control (start ignored while busy)
//   w_addr/w_data            : synchronous weight memory read port
//   pix_valid/ready/data/label: pixel stream handshake
//   pred_valid/pred/pred_z   : per-sample result (pred/pred_z held)
//   correct_cnt              : correct predictions in the current run
//   conf_tp/fp/tn/fn         : confusion counters, built only when
//                              NN_EVAL_CONFUSION_EN is defined (else 0)
module nn_eval_scorer
    import nn_eval_pkg::*;
#(
    parameter int N_PIX     = N_PIX_DEF,
    parameter int N_SAMPLES = N_SAMPLES_DEF,
    parameter int W_W       = W_W_DEF,
    parameter int PIX_W     = PIX_W_DEF,
    parameter int ACC_W     = ACC_W_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    output logic                             busy,
    output logic [$clog2(N_PIX)-1:0]         w_addr,
    input  logic signed [W_W-1:0]            w_data,
    input  logic                             pix_valid,
    input  logic [PIX_W-1:0]                 pix_data,
    input  logic                             pix_label,
    output logic                             pix_ready,
    output logic                             pred_valid,
    output logic                             pred,
    output logic [ACC_W-1:0]                 pred_z,
    output logic [$clog2(N_SAMPLES+1)-1:0]   correct_cnt,
    output logic                             done,
    output logic [$clog2(N_SAMPLES+1)-1:0]   conf_tp,
    output logic [$clog2(N_SAMPLES+1)-1:0]   conf_fp,
    output logic [$clog2(N_SAMPLES+1)-1:0]   conf_tn,
    output logic [$clog2(N_SAMPLES+1)-1:0]   conf_fn
);

    localparam int AW = $clog2(N_PIX);
    localparam int CW = $clog2(N_SAMPLES+1);
    localparam int SW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam logic [AW-1:0] LAST_PIX    = AW'(N_PIX-1);
    localparam logic [SW-1:0] LAST_SAMPLE = SW'(N_SAMPLES-1);

    state_t                  state_reg, state_next;
    logic [AW-1:0]           pix_idx_reg;
    logic [SW-1:0]           sample_idx_reg;
    logic                    label_reg;
    logic                    pred_reg;
    logic [ACC_W-1:0]        pred_z_reg;
    logic [CW-1:0]           correct_reg;
    logic signed [ACC_W-1:0] mac_acc;
    logic                    hs;
    logic                    decide_pred;

    assign hs          = (state_reg == ACCEPT) && pix_valid;
    assign decide_pred = ~mac_acc[ACC_W-1];

    nn_eval_mac #(
        .W_W   (W_W),
        .PIX_W (PIX_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk       (clk),
        .rst       (rst),
        .en        (hs),
        .clr_first (pix_idx_reg == '0),
        .pix       (pix_data),
        .w         (w_data),
        .acc       (mac_acc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (start) state_next = FETCH;
            FETCH:   state_next = ACCEPT;
            ACCEPT:  if (pix_valid) state_next = (pix_idx_reg == LAST_PIX) ? DECIDE : FETCH;
            DECIDE:  state_next = (sample_idx_reg == LAST_SAMPLE) ? FINISH : FETCH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Indices, label and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_idx_reg    <= '0;
            sample_idx_reg <= '0;
            label_reg      <= LABEL_NEG;
            pred_reg       <= 1'b0;
            pred_z_reg     <= '0;
            correct_reg    <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (start) begin
                        pix_idx_reg    <= '0;
                        sample_idx_reg <= '0;
                        correct_reg    <= '0;
                    end
                end
                ACCEPT: begin
                    if (pix_valid) begin
                        if (pix_idx_reg == '0) label_reg <= pix_label;
                        // The last index is held; DECIDE rewinds it.
                        if (pix_idx_reg != LAST_PIX) pix_idx_reg <= pix_idx_reg + 1'b1;
                    end
                end
                DECIDE: begin
                    pred_reg   <= decide_pred;
                    pred_z_reg <= mac_acc;
                    if (decide_pred == label_reg) correct_reg <= correct_reg + 1'b1;
                    if (sample_idx_reg != LAST_SAMPLE) begin
                        sample_idx_reg <= sample_idx_reg + 1'b1;
                        pix_idx_reg    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // pix_idx is itself a register, so the read address is registered and
    // stays put while ACCEPT waits for a pixel.
    assign w_addr      = pix_idx_reg;
    assign correct_cnt = correct_reg;

    // Outputs; pred/pred_z bypass their registers during DECIDE so the
    // result is already visible alongside pred_valid.
    always_comb begin
        busy       = (state_reg != IDLE);
        pix_ready  = (state_reg == ACCEPT);
        pred_valid = (state_reg == DECIDE);
        done       = (state_reg == FINISH);
        pred       = pred_reg;
        pred_z     = pred_z_reg;
        if (state_reg == DECIDE) begin
            pred   = decide_pred;
            pred_z = mac_acc;
        end
    end

`ifdef NN_EVAL_CONFUSION_EN
    logic [CW-1:0] tp_reg, fp_reg, tn_reg, fn_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            tp_reg <= '0;
            fp_reg <= '0;
            tn_reg <= '0;
            fn_reg <= '0;
        end else if (state_reg == IDLE && start) begin
            tp_reg <= '0;
            fp_reg <= '0;
            tn_reg <= '0;
            fn_reg <= '0;
        end else if (state_reg == DECIDE) begin
            unique case ({decide_pred, label_reg})
                {LABEL_POS, LABEL_POS}: tp_reg <= tp_reg + 1'b1;
                {LABEL_POS, LABEL_NEG}: fp_reg <= fp_reg + 1'b1;
                {LABEL_NEG, LABEL_NEG}: tn_reg <= tn_reg + 1'b1;
                default:                fn_reg <= fn_reg + 1'b1;
            endcase
        end
    end

    assign conf_tp = tp_reg;
    assign conf_fp = fp_reg;
    assign conf_tn = tn_reg;
    assign conf_fn = fn_reg;
`else
    assign conf_tp = '0;
    assign conf_fp = '0;
    assign conf_tn = '0;
    assign conf_fn = '0;
`endif

endmodule

// File: tb/tb_nn_eval_scorer.sv
// tb_nn_eval_scorer -- directed, table-driven bench for nn_eval_scorer
// (N_PIX=784, N_SAMPLES=2) with a synchronous weight ROM model.
module tb_nn_eval_scorer;

    localparam int NP  = 784;
    localparam int NS  = 2;
    localparam int AW  = $clog2(NP);
    localparam int CW  = $clog2(NS+1);
    localparam int ACC = 48;
    localparam int RUN_LEN = NS*(2*NP+1) + 1;   // start cycle to done cycle

`ifdef NN_EVAL_CONFUSION_EN
    localparam bit CONF_ON = 1'b1;
`else
    localparam bit CONF_ON = 1'b0;
`endif

    typedef struct {
        int     wsel;
        int     ps0, ps1;
        bit     l0, l1;
        longint z0, z1;
        bit     p0, p1;
        int     corr;
        int     tp, fp, tn, fn;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst, start, busy;
    logic [AW-1:0]        w_addr;
    logic signed [15:0]   w_data;
    logic                 pix_valid, pix_label, pix_ready;
    logic [7:0]           pix_data;
    logic                 pred_valid, pred, done;
    logic [ACC-1:0]       pred_z;
    logic [CW-1:0]        correct_cnt, conf_tp, conf_fp, conf_tn, conf_fn;

    nn_eval_scorer #(
        .N_PIX(NP), .N_SAMPLES(NS), .W_W(16), .PIX_W(8), .ACC_W(ACC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .w_addr(w_addr), .w_data(w_data),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_label(pix_label),
        .pix_ready(pix_ready), .pred_valid(pred_valid), .pred(pred),
        .pred_z(pred_z), .correct_cnt(correct_cnt), .done(done),
        .conf_tp(conf_tp), .conf_fp(conf_fp), .conf_tn(conf_tn), .conf_fn(conf_fn)
    );

    always #5 clk = ~clk;

    // Synchronous weight ROM
    logic signed [15:0] wmem [NP];
    always @(posedge clk) w_data <= wmem[w_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record every pred_valid and done
    int                 pv_cnt = 0, done_cnt = 0, done_cyc = 0;
    logic signed [47:0] pv_z [64];
    logic               pv_pred [64];
    always @(negedge clk) begin
        if (pred_valid) begin
            if (pv_cnt < 64) begin
                pv_z[pv_cnt]    = pred_z;
                pv_pred[pv_cnt] = pred;
            end
            pv_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic signed [15:0] wfun(input int sel, input int i);
        case (sel)
            0:       return 16'sd0;
            1:       return (i == 0) ? 16'sd1 : 16'sd0;
            2:       return -16'sd1;
            3:       return (i % 2 == 1) ? -16'sd3 : 16'sd2;
            default: return 16'sd32767;
        endcase
    endfunction

    function automatic logic [7:0] pfun(input int sel, input int i);
        case (sel)
            0:       return 8'd0;
            1:       return (i == 0) ? 8'd255 : 8'd0;
            2:       return 8'd1;
            3:       return 8'd10;
            4:       return 8'd255;
            default: return 8'(i);
        endcase
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " pix_ready"}, pix_ready, 0);
        chk({tag, " pred_valid"}, pred_valid, 0);
        chk({tag, " pred"}, pred, 0);
        chk({tag, " pred_z"}, longint'(pred_z), 0);
        chk({tag, " correct_cnt"}, correct_cnt, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " w_addr"}, w_addr, 0);
        chk({tag, " conf_tp"}, conf_tp, 0);
        chk({tag, " conf_fp"}, conf_fp, 0);
        chk({tag, " conf_tn"}, conf_tn, 0);
        chk({tag, " conf_fn"}, conf_fn, 0);
    endtask

    // Stream all samples. Options: hold pix_valid low for gap_len ready
    // cycles before pixel gap_p of sample gap_s; assert rst instead of
    // pixel rst_p of sample rst_s (aborted=1); pulse start at (bst_s,bst_p).
    task automatic feed(input int ps0, input int ps1, input bit l0, input bit l1,
                        input int gap_s, input int gap_p, input int gap_len,
                        input int rst_s, input int rst_p,
                        input int bst_s, input int bst_p, output bit aborted);
        int s = 0, p = 0, stall = gap_len, budget = 0;
        bit running = 1'b1;
        aborted = 1'b0;
        while (running) begin
            @(negedge clk);
            start = 1'b0;
            budget++;
            if (budget > 8000) begin
                chk("feed timeout", budget, 0);
                running = 1'b0;
            end else if (s == rst_s && p == rst_p && pix_ready) begin
                rst       = 1'b1;
                pix_valid = 1'b0;
                aborted   = 1'b1;
                running   = 1'b0;
            end else begin
                if (s == bst_s && p == bst_p && pix_ready) start = 1'b1;
                if (s == gap_s && p == gap_p && stall > 0 && pix_ready) begin
                    pix_valid = 1'b0;
                    stall--;
                end else begin
                    pix_valid = 1'b1;
                    pix_data  = pfun((s == 0) ? ps0 : ps1, p);
                    // Only pixel 0 carries the real label.
                    pix_label = (p == 0) ? ((s == 0) ? l0 : l1) : ~((s == 0) ? l0 : l1);
                end
                if (pix_valid && pix_ready) begin
                    p++;
                    if (p == NP) begin
                        p = 0;
                        s++;
                        if (s == NS) running = 1'b0;
                    end
                end
            end
        end
        if (!aborted) begin
            @(negedge clk);
            pix_valid = 1'b0;
        end
    endtask

    task automatic do_run(input vec_t v, input string tag, input int gap_len,
                          input int bst_s, input bit release_rst);
        int  pv0, dn0, t0, k;
        bit  ab;
        for (int i = 0; i < NP; i++) wmem[i] = wfun(v.wsel, i);
        pv0 = pv_cnt;
        dn0 = done_cnt;
        @(negedge clk);
        if (release_rst) rst = 1'b0;
        start = 1'b1;
        t0    = cyc;
        feed(v.ps0, v.ps1, v.l0, v.l1, 0, 3, gap_len, -1, -1, bst_s, 1, ab);
        k = 0;
        while (done_cnt == dn0 && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk({tag, " done seen"}, done_cnt - dn0, 1);
        chk({tag, " run length"}, done_cyc - t0, RUN_LEN + gap_len);
        chk({tag, " pred_valid count"}, pv_cnt - pv0, NS);
        chk({tag, " z0"}, pv_z[pv0], v.z0);
        chk({tag, " z1"}, pv_z[pv0+1], v.z1);
        chk({tag, " pred0"}, pv_pred[pv0], v.p0);
        chk({tag, " pred1"}, pv_pred[pv0+1], v.p1);
        chk({tag, " correct_cnt"}, correct_cnt, v.corr);
        chk({tag, " conf_tp"}, conf_tp, CONF_ON ? v.tp : 0);
        chk({tag, " conf_fp"}, conf_fp, CONF_ON ? v.fp : 0);
        chk({tag, " conf_tn"}, conf_tn, CONF_ON ? v.tn : 0);
        chk({tag, " conf_fn"}, conf_fn, CONF_ON ? v.fn : 0);
        repeat (3) @(negedge clk);
        #1;
        chk({tag, " single done"}, done_cnt - dn0, 1);
        chk({tag, " idle busy"}, busy, 0);
        chk({tag, " held pred"}, pred, v.p1);
        chk({tag, " held pred_z"}, $signed(pred_z), v.z1);
        chk({tag, " held correct"}, correct_cnt, v.corr);
        $display("run %s: correct_cnt=%0d z0=%0d z1=%0d", tag, correct_cnt, pv_z[pv0], pv_z[pv0+1]);
    endtask

    vec_t vecs [5];

    initial begin
        bit ab;
        int dn0;
        //          wsel ps0 ps1 l0 l1 z0                  z1               p0 p1 corr tp fp tn fn
        vecs[0] = '{0,   5,  5,  1, 0, 0,                  0,               1, 1, 1,   1, 1, 0, 0};
        vecs[1] = '{1,   1,  0,  1, 1, 65280,              0,               1, 1, 2,   2, 0, 0, 0};
        vecs[2] = '{2,   2,  2,  0, 1, -200704,            -200704,         0, 0, 1,   0, 0, 1, 1};
        vecs[3] = '{3,   3,  4,  0, 0, -1003520,           -25589760,       0, 0, 2,   0, 0, 2, 0};
        vecs[4] = '{4,   4,  2,  1, 0, 64'd1676999331840,  64'd6576467968,  1, 1, 1,   1, 1, 0, 0};

        rst       = 1'b1;
        start     = 1'b0;
        pix_valid = 1'b0;
        pix_data  = '0;
        pix_label = 1'b0;
        for (int i = 0; i < NP; i++) wmem[i] = '0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int r = 0; r < 5; r++) do_run(vecs[r], $sformatf("vec%0d", r), 0, -1, 1'b0);

        // Stall of 5 ready cycles before pixel 3: same result, 5 cycles longer
        do_run(vecs[2], "gap5", 5, -1, 1'b0);

        // start pulsed mid-run must not restart or clear anything
        do_run(vecs[3], "start_busy", 0, 1, 1'b0);

        // Reset during sample 1 pixel 3, then restart right after release
        for (int i = 0; i < NP; i++) wmem[i] = wfun(1, i);
        dn0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        feed(1, 0, 1'b1, 1'b1, -1, -1, 0, 1, 3, -1, -1, ab);
        chk("abort reached", ab, 1);
        @(negedge clk);
        #1;
        check_reset_values("abort");
        chk("abort no done", done_cnt - dn0, 0);
        do_run(vecs[1], "after_abort", 0, -1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nn_eval_scorer.md
# nn_eval_scorer

Downstream evaluation stage for the single-neuron trainer. After training completes, it reads the trained weight vector from weight storage and streams held-out test images pixel by pixel. For each image it computes the forward-pass dot product and thresholds it at sigmoid(z) ≥ 0.5, i.e. z ≥ 0. It compares the prediction against the supplied label and accumulates an accuracy count.

## Interface
Parameters:
- N_PIX, 784: pixels per image; also weight vector length.
- N_SAMPLES, 40: test images per evaluation run.
- W_W, 16: signed weight width.
- PIX_W, 8: unsigned pixel width.
- ACC_W, 48: signed accumulator width.

Ports:
- clk  in  1: single clock; all state changes on rising edge.
- rst  in  1: synchronous, active-high reset.
- start  in  1: one-cycle pulse that begins a run. Ignored while busy=1.
- busy  out  1: high from the cycle after an accepted start until done.
- w_addr  out  $clog2(N_PIX): weight read address, registered.
- w_data  in  W_W: signed weight; valid one cycle after w_addr changes (synchronous ROM/RAM read).
- pix_valid  in  1: upstream pixel valid.
- pix_data  in  PIX_W: unsigned pixel.
- pix_label  in  1: sample label; sampled only on the handshake of pixel 0.
- pix_ready  out  1: block accepts a pixel this cycle.
- pred_valid  out  1: one-cycle pulse per sample.
- pred  out  1: prediction; held until the next pred_valid.
- pred_z  out  ACC_W: signed final dot product for the sample; held.
- correct_cnt  out  $clog2(N_SAMPLES+1): count of samples where pred == label.
- done  out  1: one-cycle pulse at the end of a run.
- conf_tp, conf_fp, conf_tn, conf_fn  out  $clog2(N_SAMPLES+1) each: confusion counters (see Configuration).

## Operation
- FSM states: IDLE, FETCH, ACCEPT, DECIDE, FINISH.
- IDLE:
  - On start: clear pix_idx, sample_idx, correct_cnt and the confusion counters; go to FETCH.
- FETCH:
  - w_addr = pix_idx for one cycle, so w_data becomes aligned; go to ACCEPT.
- ACCEPT:
  - pix_ready = 1.
  - On pix_valid & pix_ready:
    - Form operand x = {1'b0, pix_data, 8'b0}, i.e. Q8.8 with the pixel as the integer part.
    - Form product = x * w_data, signed, sign-extended to ACC_W.
    - acc = (pix_idx == 0 ? 0 : acc) + product.
    - On pix_idx == 0, capture the label.
    - If pix_idx == N_PIX-1, go to DECIDE. Otherwise pix_idx++ and go to FETCH.
  - Without a handshake: stay in ACCEPT; w_addr is held.
- DECIDE:
  - pred = ~acc[ACC_W-1], so z ≥ 0 gives 1.
  - pred_z = acc; pred_valid = 1.
  - correct_cnt += (pred == label).
  - If sample_idx == N_SAMPLES-1, go to FINISH. Otherwise sample_idx++, pix_idx = 0, go to FETCH.
- FINISH:
  - done = 1 for one cycle; go to IDLE.
  - correct_cnt, pred and pred_z hold until the next accepted start.
- Arithmetic:
  - No saturation; accumulation wraps modulo 2^ACC_W.
  - 48 bits covers the full range of 784 × 17-bit × 16-bit products.

## Timing
- Reset values: busy=0, pix_ready=0, pred_valid=0, pred=0, pred_z=0, correct_cnt=0, done=0, w_addr=0, all confusion counters=0; state = IDLE.
- rst asserted mid-run: abort immediately to the reset values, with no done pulse. A start in the first cycle after rst deasserts is accepted.
- Throughput: at most one pixel every 2 cycles, because pix_ready is always low in the cycle after a handshake.
- Latency:
  - Final-pixel handshake → pred_valid: 1 cycle.
  - Last pred_valid → done: 1 cycle.
- Uninterrupted run length: 1 + N_SAMPLES × (2·N_PIX + 1) + 1 cycles from start to done.
- pix_valid may drop at any time. Accumulator and indices hold while no handshake occurs.
- start coincident with done is ignored, since the block is still busy that cycle.

## Configuration
- NN_EVAL_CONFUSION_EN defined:
  - In DECIDE, exactly one of conf_tp / conf_fp / conf_tn / conf_fn increments, according to (pred, label): (1,1)=tp, (1,0)=fp, (0,0)=tn, (0,1)=fn.
  - All four clear on start.
- NN_EVAL_CONFUSION_EN undefined:
  - The counters are not built; the conf_* ports remain and are tied to 0.

## Structure
- Shared package nn_eval_pkg holds:
  - the FSM state enum;
  - defaults for N_PIX, N_SAMPLES, W_W, PIX_W, ACC_W;
  - the pixel Q-format shift constant (8);
  - the LABEL_POS=1 / LABEL_NEG=0 constants.
- One sub-module, nn_eval_mac: signed multiply plus accumulate/clear, with a clear-on-first input and an enable.

## Test plan
- N_PIX=4, N_SAMPLES=2, all weights 0, labels 1 then 0 → pred_z=0 and pred=1 for both samples; correct_cnt=1; done pulses once.
- w[0]=1, others 0; pixel0=255, rest 0; label 1 → pred_z=65280, pred=1, correct_cnt increments by 1.
- All weights −1, all pixels 1, N_PIX=784, label 0 → pred_z=−200704, pred=0, counted correct.
- Same stimulus as the −1 case, but pix_valid dropped for 5 cycles after pixel 2 → identical pred_z; total run length extended by exactly 5 cycles.
- rst pulsed during sample 1, pixel 3 → next cycle all outputs are at reset values with no done; a fresh start then completes normally.
- start pulsed while busy → no effect on counters. With NN_EVAL_CONFUSION_EN and labels/preds (1,1),(0,1) → conf_tp=1, conf_fp=1, conf_tn=0, conf_fn=0.
